// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Cycles from the accepting edge to the edge that raises rspN_valid.
    localparam int unsigned RSP_LAT = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester/response/memory bundle for the data memory arbiter
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          rsp0_err;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          rsp1_err;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus the memory itself.
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - stateless two-way round-robin grant logic
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);

    // One-hot grant: on a tie the port that did not win last time goes first.
    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (valid0_i && valid1_i) begin
                grant_o = (last_grant_i == PORT0) ? 2'b10 : 2'b01;
            end else begin
                grant_o = {valid1_i, valid0_i};
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin sequencer for the single-port data memory (optional DMEM_ARB_RANGE_CHECK_EN)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    state_t        state_q;
    logic          last_grant_q;
    logic          owner_q;
    logic          we_q;
    logic          addr_err_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata_q;
    logic          rsp_err_q;
    logic [1:0]    rsp_valid_q;

    logic [1:0]    grant;
    logic          win_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          range_err;

    // Grants only in IDLE; held off during reset so no handshake is seen by a requester.
    rr_arbiter2 u_rr (
        .valid0_i     (bus.req0_valid),
        .valid1_i     (bus.req1_valid),
        .last_grant_i (last_grant_q),
        .en_i         ((state_q == IDLE) && !rst),
        .grant_o      (grant)
    );

    assign win_id    = grant[1] ? PORT1 : PORT0;
    assign sel_we    = grant[1] ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = grant[1] ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = grant[1] ? bus.req1_wdata : bus.req0_wdata;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
    assign range_err = (sel_addr >= DEPTH_W);
`else
    assign range_err = 1'b0;
`endif

    // Sequencer: latch the winner, run one memory cycle, then pulse the owner's response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            owner_q      <= PORT0;
            we_q         <= 1'b0;
            addr_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= 2'b00;
                    if (grant != 2'b00) begin
                        owner_q      <= win_id;
                        last_grant_q <= win_id;
                        we_q         <= sel_we;
                        addr_err_q   <= range_err;
                        mem_addr_q   <= sel_addr;
                        mem_wdata_q  <= sel_wdata;
                        // Write enable is only ever high during the ACCESS cycle.
                        mem_we_q     <= sel_we && !range_err;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q  <= 1'b0;
                    rdata_q   <= (we_q || addr_err_q) ? '0 : bus.mem_rdata;
                    rsp_err_q <= addr_err_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= (owner_q == PORT1) ? 2'b10 : 2'b01;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_rdata = rdata_q;
    assign bus.rsp1_rdata = rdata_q;
    assign bus.rsp0_err   = rsp_err_q;
    assign bus.rsp1_err   = rsp_err_q;

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .DEPTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:1023];

    assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    // Present a request, wait (bounded) for ready, return just after the accepting edge.
    task automatic issue(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
        int  waited;
        bit  got;
        waited = 0;
        got    = 1'b0;
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
        while (!got && waited < 12) begin
            @(negedge clk);
            if ((p == 0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
            else waited++;
        end
        chk({tag, "_accept"}, 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (p == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    // Follow a transaction from its ACCESS cycle to the response pulse.
    task automatic expect_rsp(input int p, input logic exp_we, input logic [31:0] exp_rdata,
                              input logic exp_err, input string tag);
        @(negedge clk);
        chk({tag, "_access_we"}, 32'(bus.mem_we), 32'(exp_we));
        chk({tag, "_access_rsp"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_resp_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_early_rsp"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid},
            (p == 0) ? 32'd1 : 32'd2);
        chk({tag, "_rdata"}, (p == 0) ? bus.rsp0_rdata : bus.rsp1_rdata, exp_rdata);
        chk({tag, "_err"}, 32'((p == 0) ? bus.rsp0_err : bus.rsp1_err), 32'(exp_err));
        @(posedge clk);
        #1;
        chk({tag, "_rsp_drop"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    endtask

    logic        exp_range_we;
    logic        exp_range_err;
    logic [31:0] exp_mem300;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        drive_idle();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        chk("rst_err", {30'd0, bus.rsp1_err, bus.rsp0_err}, 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", bus.rsp0_rdata, 32'd0);
        drive_idle();
        rst = 1'b0;

        // Write then read back on port 0.
        issue(0, 1'b1, 32'd5, 32'hDEAD_BEEF, "wr5");
        chk("wr5_mem_addr", bus.mem_addr, 32'd5);
        expect_rsp(0, 1'b1, 32'd0, 1'b0, "wr5");
        chk("wr5_mem", mem[5], 32'hDEAD_BEEF);
        issue(0, 1'b0, 32'd5, 32'd0, "rd5");
        expect_rsp(0, 1'b0, 32'hDEAD_BEEF, 1'b0, "rd5");

        // Port 0 writes, port 1 reads the same word next.
        issue(0, 1'b1, 32'd7, 32'h1234_5678, "wr7");
        expect_rsp(0, 1'b1, 32'd0, 1'b0, "wr7");
        issue(1, 1'b0, 32'd7, 32'd0, "rd7");
        expect_rsp(1, 1'b0, 32'h1234_5678, 1'b0, "rd7");

        // Out-of-range write on port 1.
`ifdef DMEM_ARB_RANGE_CHECK_EN
        exp_range_we  = 1'b0;
        exp_range_err = 1'b1;
        exp_mem300    = 32'h1000_012C;
`else
        exp_range_we  = 1'b1;
        exp_range_err = 1'b0;
        exp_mem300    = 32'hCAFE_F00D;
`endif
        issue(1, 1'b1, 32'd300, 32'hCAFE_F00D, "wr300");
        expect_rsp(1, exp_range_we, 32'd0, exp_range_err, "wr300");
        chk("wr300_mem", mem[300], exp_mem300);

        // Fresh reset, both ports valid continuously: grants alternate 0,1,0,1 every 3 cycles.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 32'd10;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 32'd11;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            chk($sformatf("alt%0d_ready", g), {30'd0, bus.req1_ready, bus.req0_ready},
                (g % 2 == 0) ? 32'd1 : 32'd2);
            if (g > 0) begin
                chk($sformatf("alt%0d_prev_rsp", g), {30'd0, bus.rsp1_valid, bus.rsp0_valid},
                    (g % 2 == 0) ? 32'd2 : 32'd1);
                chk($sformatf("alt%0d_prev_rdata", g), bus.rsp0_rdata,
                    (g % 2 == 0) ? 32'h1000_000B : 32'h1000_000A);
            end
            @(negedge clk);
            chk($sformatf("alt%0d_busy_ready", g), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            chk($sformatf("alt%0d_addr", g), bus.mem_addr,
                (g % 2 == 0) ? 32'd10 : 32'd11);
            chk($sformatf("alt%0d_we", g), 32'(bus.mem_we), 32'd0);
            @(negedge clk);
            chk($sformatf("alt%0d_resp_ready", g), {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            chk($sformatf("alt%0d_resp_rsp", g), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        end
        @(negedge clk);
        chk("alt_last_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
        chk("alt_last_rdata", bus.rsp1_rdata, 32'h1000_000B);
        drive_idle();
        @(posedge clk);
        #1;

        // Reset asserted during the ACCESS cycle of a read.
        issue(0, 1'b0, 32'd10, 32'd0, "rstrd");
        #2;
        rst = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("rstrd_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rstrd_mem_addr", bus.mem_addr, 32'd0);
        chk("rstrd_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rstrd_rdata", bus.rsp0_rdata, 32'd0);
        chk("rstrd_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        drive_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < RSP_LAT + 1; k++) begin
            @(negedge clk);
            chk($sformatf("rstrd_norsp%0d", k), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
